// File: rtl/upd7800_pkg.sv
// upd7800_pkg: constants and types shared by the uPD7800 core blocks.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: interrupt index of INTFT, timer widths, TC view struct.
package upd7800_pkg;

  // Bit position of the timer request within the core's intp vector.
  localparam int II_INTT  = 1;

  // Timer geometry: 12-bit down-counter above a 3-bit prescaler.
  localparam int TIMER_CW = 12;
  localparam int TIMER_PW = 3;

  // Packed view of TC[14:0] as {counter, prescaler}.
  typedef struct packed {
    logic [TIMER_CW-1:0] cnt;
    logic [TIMER_PW-1:0] pre;
  } tc_t;

endpackage

// File: rtl/upd7800_timer_presc.sv
// upd7800_timer_presc: PW-bit down-counting prescaler, load-to-max, wrap strobe.
// Latency: pre updates on the CLK after en/load; wrap is combinational from pre and en.
// Backpressure: none; en is a plain enable, load has priority over en.
// Ports: clk, rst (sync, active-high), en (count), load (force max),
//        pre (current value), wrap (en while pre==0: counter steps this CLK).
module upd7800_timer_presc #(
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  output logic [PW-1:0] pre,
  output logic          wrap
);

  localparam logic [PW-1:0] PRE_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= PRE_MAX;
    end else if (load) begin
      pre <= PRE_MAX;
    end else if (en) begin
      // Decrement from 0 wraps naturally to all-ones.
      pre <= pre - PW'(1);
    end
  end

  assign wrap = en && !load && (pre == '0);

endmodule

// File: rtl/upd7800_timer_ctl.sv
// upd7800_timer_ctl: uPD7800 interval timer (prescaler + 12-bit counter, TM reload, INTFT).
// Latency: all outputs registered; reload lands one CLK after the TC_UF strobe.
// Backpressure: none; TICK/STM/TM_WE/INTFT_CLR are single-CLK strobes, never stalled.
// Ports: CLK, RES (sync active-high), TICK (prescaler enable), TM_WE/TM_DI (TM write),
//        STM (restart from TM), INTFT_CLR (clear request); TC {cnt,pre}, TC_UF (underflow
//        strobe), INTFT (request flag), TM_Q (modulus register).
module upd7800_timer_ctl
  import upd7800_pkg::*;
#(
  parameter int                 CW       = TIMER_CW,
  parameter int                 PW       = TIMER_PW,
  parameter logic [CW-1:0]      TM_RESET = '1
) (
  input  logic                 CLK,
  input  logic                 RES,
  input  logic                 TICK,
  input  logic                 TM_WE,
  input  logic [CW-1:0]        TM_DI,
  input  logic                 STM,
  input  logic                 INTFT_CLR,
  output logic [CW+PW-1:0]     TC,
  output logic                 TC_UF,
  output logic                 INTFT,
  output logic [CW-1:0]        TM_Q
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] tm_q;
  logic [CW-1:0] tm_next;
  logic [PW-1:0] pre;
  // Set on the underflow CLK; it is both the visible TC_UF strobe and the
  // "reload on the next CLK" request, since the two always coincide.
  logic          pending;
  logic          intft;

  logic          tc_zero;
  logic          uf_hit;
  logic          reload;
  logic          pre_en;
  logic          pre_load;
  logic          pre_wrap;

  // A TM write coincident with STM or reload is written through to the counter.
  assign tm_next  = TM_WE ? TM_DI : tm_q;

  assign tc_zero  = (cnt == '0) && (pre == '0);

  // STM outranks a pending reload, which outranks TICK.
  assign reload   = pending && !STM;
  assign pre_load = STM || pending;
  assign uf_hit   = TICK && !pre_load && tc_zero;
  // At TC==0 the tick is consumed by underflow detection: TC holds at zero.
  assign pre_en   = TICK && !pre_load && !tc_zero;

  upd7800_timer_presc #(
    .PW (PW)
  ) u_presc (
    .clk  (CLK),
    .rst  (RES),
    .en   (pre_en),
    .load (pre_load),
    .pre  (pre),
    .wrap (pre_wrap)
  );

  always_ff @(posedge CLK) begin
    if (RES) begin
      cnt     <= TM_RESET;
      tm_q    <= TM_RESET;
      pending <= 1'b0;
      intft   <= 1'b0;
    end else begin
      tm_q <= tm_next;

      if (pre_load) begin
        cnt <= tm_next;
      end else if (pre_wrap) begin
        cnt <= cnt - CW'(1);
      end

      // Cleared by STM or by the reload itself, since uf_hit is 0 then.
      pending <= uf_hit;

      // Set beats clear so a request arriving with SKIT is never lost.
      if (reload) begin
        intft <= 1'b1;
      end else if (INTFT_CLR) begin
        intft <= 1'b0;
      end
    end
  end

  assign TC    = {cnt, pre};
  assign TC_UF = pending;
  assign INTFT = intft;
  assign TM_Q  = tm_q;

endmodule

// File: tb/tb_upd7800_timer_ctl.sv
// tb_upd7800_timer_ctl: directed scenarios plus random traffic for upd7800_timer_ctl.
// A reference model treats TC as one 15-bit number decremented per TICK and pushes
// the expected outputs each CLK; a monitor pops and compares them after each edge.
module tb_upd7800_timer_ctl;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        tick = 1'b0;
  logic        tm_we = 1'b0;
  logic [11:0] tm_di = 12'h000;
  logic        stm = 1'b0;
  logic        intft_clr = 1'b0;
  logic [14:0] tc;
  logic        tc_uf;
  logic        intft;
  logic [11:0] tm_q;

  int checks = 0;
  int errors = 0;

  upd7800_timer_ctl dut (
    .CLK       (clk),
    .RES       (res),
    .TICK      (tick),
    .TM_WE     (tm_we),
    .TM_DI     (tm_di),
    .STM       (stm),
    .INTFT_CLR (intft_clr),
    .TC        (tc),
    .TC_UF     (tc_uf),
    .INTFT     (intft),
    .TM_Q      (tm_q)
  );

  always #5 clk = ~clk;

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [14:0] tc;
    logic        uf;
    logic        intf;
    logic [11:0] tm;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  bit sb_on = 1'b0;
  int m_tc;
  int m_tm;
  bit m_uf;
  bit m_int;

  always @(posedge clk) begin
    int  tm_new;
    bit  set_int;
    if (res) begin
      m_tc  = 'hFFF * 8 + 7;
      m_tm  = 'hFFF;
      m_uf  = 1'b0;
      m_int = 1'b0;
      sb_on = 1'b1;
    end else if (sb_on) begin
      tm_new  = tm_we ? int'(tm_di) : m_tm;
      set_int = 1'b0;
      if (stm) begin
        m_tc = tm_new * 8 + 7;
        m_uf = 1'b0;
      end else if (m_uf) begin
        m_tc    = tm_new * 8 + 7;
        m_uf    = 1'b0;
        set_int = 1'b1;
      end else if (tick) begin
        if (m_tc == 0) m_uf = 1'b1;
        else           m_tc = m_tc - 1;
      end
      if (set_int)        m_int = 1'b1;
      else if (intft_clr) m_int = 1'b0;
      m_tm = tm_new;
    end
    if (sb_on) sbq.push_back('{tc: 15'(m_tc), uf: m_uf, intf: m_int, tm: 12'(m_tm)});
  end

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      checks++;
      if (tc !== mon_e.tc || tc_uf !== mon_e.uf || intft !== mon_e.intf || tm_q !== mon_e.tm) begin
        errors++;
        $display("FAIL scoreboard t=%0t got tc=%h uf=%b int=%b tm=%h want tc=%h uf=%b int=%b tm=%h",
                 $time, tc, tc_uf, intft, tm_q, mon_e.tc, mon_e.uf, mon_e.intf, mon_e.tm);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic t, input logic s, input logic w,
                       input logic [11:0] d, input logic c);
    tick = t; stm = s; tm_we = w; tm_di = d; intft_clr = c;
    @(negedge clk);
    tick = 1'b0; stm = 1'b0; tm_we = 1'b0; intft_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
  endtask

  task automatic tick4(input int n);
    repeat (n) begin
      drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
      idle(3);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, req);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int pulses;
    int viol;

    // Reset and first counting steps.
    res = 1'b1;
    idle(3);
    res = 1'b0;
    chk("reset_tc", tc, {12'hFFF, 3'd7});
    chk("reset_intft", intft, 0);
    chk("reset_tm", tm_q, 12'hFFF);
    chk("reset_uf", tc_uf, 0);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
    chk("first_tick", tc, {12'hFFF, 3'd6});
    idle(3);
    tick4(7);
    chk("eight_ticks", tc, {12'hFFE, 3'd7});

    // Underflow and reload from TM=FFF.
    drive(1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
    chk("stm_zero", tc, {12'h000, 3'd7});
    drive(1'b0, 1'b0, 1'b1, 12'hFFF, 1'b0);
    chk("tm_we_no_disturb", tc, {12'h000, 3'd7});
    idle(1);
    tick4(7);
    chk("at_zero", tc, 0);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
    chk("uf_strobe", tc_uf, 1);
    chk("uf_hold", tc, 0);
    idle(1);
    chk("reload_tc", tc, {12'hFFF, 3'd7});
    chk("reload_uf", tc_uf, 0);
    chk("reload_intft", intft, 1);
    idle(2);

    // Lone clear.
    drive(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
    chk("clr_intft", intft, 0);

    // STM restart mid-count from a freshly written TM.
    drive(1'b0, 1'b0, 1'b1, 12'h0FA, 1'b0);
    tick4(3);
    drive(1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
    chk("stm_restart", tc, {12'h0FA, 3'd7});
    chk("stm_intft", intft, 0);
    idle(3);
    tick4(8);
    chk("stm_8ticks", tc, {12'h0F9, 3'd7});
    chk("stm_8ticks_intft", intft, 0);

    // STM on the same CLK that shows TC_UF: restart wins, no request.
    drive(1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 12'h123, 1'b0);
    idle(3);
    tick4(7);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
    chk("coll_uf", tc_uf, 1);
    drive(1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
    chk("coll_tc", tc, {12'h123, 3'd7});
    chk("coll_uf_cancel", tc_uf, 0);
    idle(2);
    chk("coll_intft", intft, 0);

    // INTFT_CLR on the reload CLK: set wins.
    drive(1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
    idle(3);
    tick4(7);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
    chk("race_intft", intft, 1);
    chk("race_tc", tc, {12'h000, 3'd7});
    idle(2);
    drive(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
    chk("late_clr", intft, 0);

    // TM=0 streaming for 40 ticks.
    drive(1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
    pulses = 0;
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
      if (tc_uf) pulses++;
      if (tc[14:3] != 0) viol++;
      for (int j = 0; j < 3; j++) begin
        idle(1);
        if (tc_uf) pulses++;
        if (tc[14:3] != 0) viol++;
      end
    end
    chk("stream_pulses", pulses, 5);
    chk("stream_cnt_zero", viol, 0);
    chk("stream_intft", intft, 1);

    // Random traffic, mostly small TM values so underflows are frequent.
    for (int i = 0; i < 3000; i++) begin
      res = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 3) == 0,
            $urandom_range(0, 29) == 0,
            $urandom_range(0, 9) == 0,
            ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 2)),
            $urandom_range(0, 7) == 0);
    end
    res = 1'b0;
    idle(3);
    chk("sb_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
